// File: rtl/top_top.sv
// bfloat16 log2 unit: four register levels, one operand per cycle.
// Define FLOG_SUBNORMAL_EN to normalize subnormals instead of flushing.
module top_top (
  input  logic       clk,
  input  logic       rst,
  input  logic       sign,
  input  logic [7:0] exponent,
  input  logic [6:0] fractional,
  input  logic       input_valid,
  output logic       s_res_o,
  output logic [7:0] e_res_o,
  output logic [6:0] f_res_o,
  output logic       valid_o
);

  localparam logic [15:0] QNAN = 16'h7FC0;
  localparam logic [15:0] NINF = 16'hFF80;
  localparam logic [15:0] PINF = 16'h7F80;

  // round(log2(1+i/128)*2^16) by repeated squaring, elaboration only
  function automatic logic [15:0] lg(input int i);
    logic [63:0] x;
    logic [63:0] sq;
    logic [17:0] b;
    x = 64'(128 + i) << 24;
    b = '0;
    for (int k = 0; k < 17; k++) begin
      sq = x * x;
      if (sq[63]) begin
        b = {b[16:0], 1'b1};
        x = sq >> 32;
      end else begin
        b = {b[16:0], 1'b0};
        x = sq >> 31;
      end
    end
    lg = 16'((b + 18'd1) >> 1);
  endfunction

  function automatic logic [4:0] lead25(input logic [24:0] a);
    lead25 = '0;
    for (int i = 0; i < 25; i++)
      if (a[i]) lead25 = 5'(i);
  endfunction

`ifdef FLOG_SUBNORMAL_EN
  function automatic logic [2:0] lead7(input logic [6:0] a);
    lead7 = '0;
    for (int i = 0; i < 7; i++)
      if (a[i]) lead7 = 3'(i);
  endfunction
`endif

  logic [15:0] lut [128];
  for (genvar g = 0; g < 128; g++) begin : g_lut
    assign lut[g] = lg(g);
  end

  logic        v0_q, v0_d;
  logic        sg0_q, sg0_d;
  logic [7:0]  ex0_q, ex0_d;
  logic [6:0]  fr0_q, fr0_d;

  logic        v1_q, v1_d;
  logic        sp1_q, sp1_d;
  logic [15:0] res1_q, res1_d;
  logic [8:0]  eu1_q, eu1_d;
  logic [15:0] l1_q, l1_d;
  logic [6:0]  fe;

  logic        v2_q, v2_d;
  logic        sp2_q, sp2_d;
  logic [15:0] res2_q, res2_d;
  logic        s2_q, s2_d;
  logic [24:0] a2_q, a2_d;
  logic [4:0]  p2_q, p2_d;
  logic [24:0] vv;

  logic        vo_q, vo_d;
  logic [15:0] out_q, out_d;
  logic [24:0] sh;
  logic [7:0]  mant;
  logic [7:0]  ex3;
  logic        rup;

  // capture the operand fields
  always_comb begin
    v0_d  = input_valid;
    sg0_d = sign;
    ex0_d = exponent;
    fr0_d = fractional;
  end

  // classify specials, get unbiased exponent and table value
  always_comb begin
`ifdef FLOG_SUBNORMAL_EN
    logic [2:0] k;
    k = lead7(fr0_q);
`endif
    v1_d   = v0_q;
    sp1_d  = 1'b0;
    res1_d = '0;
    eu1_d  = 9'(ex0_q) - 9'd127;
    fe     = fr0_q;
    if (ex0_q == 8'hFF && fr0_q != '0) begin
      sp1_d  = 1'b1;
      res1_d = QNAN;
    end else if (ex0_q == 8'h00 && fr0_q == '0) begin
      sp1_d  = 1'b1;
      res1_d = NINF;
    end else if (ex0_q == 8'hFF) begin
      sp1_d  = 1'b1;
      res1_d = sg0_q ? QNAN : PINF;
`ifndef FLOG_SUBNORMAL_EN
    end else if (ex0_q == 8'h00) begin
      sp1_d  = 1'b1;
      res1_d = NINF;
`endif
    end else if (sg0_q) begin
      sp1_d  = 1'b1;
      res1_d = QNAN;
`ifdef FLOG_SUBNORMAL_EN
    end else if (ex0_q == 8'h00) begin
      eu1_d = 9'(k) - 9'd133;
      fe    = fr0_q << (3'd7 - k);
`endif
    end
    l1_d = lut[fe];
  end

  // fixed-point log, magnitude and leading-one position
  always_comb begin
    v2_d   = v1_q;
    sp2_d  = sp1_q;
    res2_d = res1_q;
    vv     = {eu1_q, 16'h0} + {9'h0, l1_q};
    s2_d   = vv[24];
    a2_d   = vv[24] ? -vv : vv;
    p2_d   = lead25(a2_d);
  end

  // normalize, round to nearest-even, pick special or zero
  always_comb begin
    sh    = a2_q << (5'd24 - p2_q);
    rup   = sh[16] & ((|sh[15:0]) | sh[17]);
    mant  = {1'b0, sh[23:17]} + {7'h0, rup};
    ex3   = 8'(p2_q) + 8'd111 + {7'h0, mant[7]};
    vo_d  = v2_q;
    out_d = out_q;
    if (v2_q) begin
      if (sp2_q) out_d = res2_q;
      else if (a2_q == '0) out_d = 16'h0000;
      else out_d = {s2_q, ex3, mant[6:0]};
    end
  end

  // pipeline registers, all cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v0_q   <= 1'b0;
      sg0_q  <= 1'b0;
      ex0_q  <= '0;
      fr0_q  <= '0;
      v1_q   <= 1'b0;
      sp1_q  <= 1'b0;
      res1_q <= '0;
      eu1_q  <= '0;
      l1_q   <= '0;
      v2_q   <= 1'b0;
      sp2_q  <= 1'b0;
      res2_q <= '0;
      s2_q   <= 1'b0;
      a2_q   <= '0;
      p2_q   <= '0;
      vo_q   <= 1'b0;
      out_q  <= '0;
    end else begin
      v0_q   <= v0_d;
      sg0_q  <= sg0_d;
      ex0_q  <= ex0_d;
      fr0_q  <= fr0_d;
      v1_q   <= v1_d;
      sp1_q  <= sp1_d;
      res1_q <= res1_d;
      eu1_q  <= eu1_d;
      l1_q   <= l1_d;
      v2_q   <= v2_d;
      sp2_q  <= sp2_d;
      res2_q <= res2_d;
      s2_q   <= s2_d;
      a2_q   <= a2_d;
      p2_q   <= p2_d;
      vo_q   <= vo_d;
      out_q  <= out_d;
    end
  end

  assign s_res_o = out_q[15];
  assign e_res_o = out_q[14:7];
  assign f_res_o = out_q[6:0];
  assign valid_o = vo_q;

endmodule

// File: tb/tb_top_top.sv
// Scoreboard bench for top_top: directed bfloat16 log2 vectors.
// Expected values are hand-derived results of log2(x).
module tb_top_top;

  logic       clk = 1'b0;
  logic       rst;
  logic       sign;
  logic [7:0] exponent;
  logic [6:0] fractional;
  logic       input_valid;
  logic       s_res_o;
  logic [7:0] e_res_o;
  logic [6:0] f_res_o;
  logic       valid_o;

  typedef struct {
    logic [15:0] x;
    logic [15:0] r;
  } item_t;

  item_t sb[$];
  int errors = 0;
  int checks = 0;
  int vcnt = 0;

`ifdef FLOG_SUBNORMAL_EN
  localparam logic [15:0] SUB_RES = 16'hC2FE;
`else
  localparam logic [15:0] SUB_RES = 16'hFF80;
`endif

  top_top dut (
    .clk(clk),
    .rst(rst),
    .sign(sign),
    .exponent(exponent),
    .fractional(fractional),
    .input_valid(input_valid),
    .s_res_o(s_res_o),
    .e_res_o(e_res_o),
    .f_res_o(f_res_o),
    .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  // monitor: pop and compare on every result pulse
  always @(negedge clk) begin
    item_t it;
    logic [15:0] got;
    if (valid_o) begin
      vcnt++;
      checks++;
      got = {s_res_o, e_res_o, f_res_o};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid got=%h", got);
      end else begin
        it = sb.pop_front();
        if (got !== it.r) begin
          errors++;
          $display("FAIL log2(%h) got=%h exp=%h", it.x, got, it.r);
        end
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] r);
    item_t it;
    @(posedge clk);
    #1;
    {sign, exponent, fractional} = x;
    input_valid = 1'b1;
    it.x = x;
    it.r = r;
    sb.push_back(it);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      input_valid = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_%s left=%0d exp=0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    logic [16:0] o;
    o = {s_res_o, e_res_o, f_res_o, valid_o};
    checks++;
    if (o !== 17'h0) begin
      errors++;
      $display("FAIL %s got=%h exp=0", tag, o);
    end
  endtask

  initial begin
    int v0;
    rst = 1'b0;
    sign = 1'b0;
    exponent = '0;
    fractional = '0;
    input_valid = 1'b0;
    #1;
    check_zero("reset_state");
    #22;
    rst = 1'b1;

    // single shots
    send(16'h72AD, 16'h42CD); idle(5);
    send(16'h47FA, 16'h4188); idle(5);
    send(16'h3F00, 16'hBF80); idle(5);
    drain("single");

    // specials one per cycle
    send(16'h3F80, 16'h0000);
    send(16'h0000, 16'hFF80);
    send(16'hBF80, 16'h7FC0);
    send(16'h7F80, 16'h7F80);
    send(16'h7FC1, 16'h7FC0);
    send(16'h8000, 16'hFF80);
    send(16'hFF80, 16'h7FC0);
    send(16'hFFC0, 16'h7FC0);
    idle(1);
    drain("special");

    // subnormal and powers of two
    send(16'h0040, SUB_RES);
    send(16'h4000, 16'h3F80);
    send(16'h4080, 16'h4000);
    send(16'h3E80, 16'hC000);
    idle(1);
    drain("misc");

    // back-to-back stream
    send(16'h72AD, 16'h42CD);
    send(16'h47FA, 16'h4188);
    send(16'h3F00, 16'hBF80);
    send(16'h4080, 16'h4000);
    send(16'h0000, 16'hFF80);
    idle(1);
    drain("stream");

    // reset with two operands in flight
    send(16'h4000, 16'h3F80);
    send(16'h4080, 16'h4000);
    @(posedge clk);
    #1;
    input_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_zero("reset_mid");
    sb.delete();
    v0 = vcnt;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (8) @(posedge clk);
    checks++;
    if (vcnt != v0) begin
      errors++;
      $display("FAIL post_reset_valid got=%0d exp=0", vcnt - v0);
    end

    send(16'h3E80, 16'hC000);
    idle(1);
    drain("resume");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
